// File: rtl/satd_pkg.sv
// Shared types and default widths for the SATD engine and its job scheduler.
package satd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } sched_state_e;

   localparam int SATD_W_DEF = 16;
   localparam int ACC_W_DEF  = 18;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pri_q names the requester favoured on a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic [1:0] gnt
);

   logic pri_q;
   logic pri_d;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = pri_q ? 2'b10 : 2'b01;
      end
      pri_d = pri_q;
      if (upd) begin
         pri_d = ~upd_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_q <= 1'b0;
      end else begin
         pri_q <= pri_d;
      end
   end

endmodule

// File: rtl/satd_job_scheduler.sv
// Shares one SATD engine between two requesters, one multi-sub-block job
// at a time, accumulating the per-sub-block results into a job total.
module satd_job_scheduler
   import satd_pkg::*;
#(
   parameter int SUB_BLOCKS = 4,
   parameter int SATD_W     = SATD_W_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int ADDR_W     = 8,
   parameter int TIMEOUT    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] req_base0,
   input  logic [ADDR_W-1:0] req_base1,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic              eng_start,
   output logic [ADDR_W-1:0] eng_addr,
   input  logic              eng_done,
   input  logic [SATD_W-1:0] eng_satd,
   output logic              res_valid,
   output logic [ACC_W-1:0]  res_sum,
   output logic [1:0]        res_owner,
   output logic              res_err
);

   localparam int SUB_W = (SUB_BLOCKS > 1) ? $clog2(SUB_BLOCKS) : 1;
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_BLOCKS - 1);
   localparam logic [TMO_W-1:0] TMO_ARM  = TMO_W'(TIMEOUT - 2);

   sched_state_e      state_q, state_d;
   logic [SUB_W-1:0]  sub_q, sub_d, sub_nxt;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ADDR_W-1:0] base_q, base_d, base_sel;
   logic              err_q, err_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              start_q, start_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rv_q, rv_d;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [1:0]        own_q, own_d;
   logic              rerr_q, rerr_d;
   logic [1:0]        arb_gnt;
   logic              upd;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .upd     (upd),
      .upd_idx (gnt_q[1]),
      .gnt     (arb_gnt)
   );

   assign base_sel = arb_gnt[1] ? req_base1 : req_base0;
   assign sub_nxt  = sub_q + SUB_W'(1);

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      tmo_d   = tmo_q;
      acc_d   = acc_q;
      base_d  = base_q;
      err_d   = err_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      start_d = 1'b0;
      addr_d  = addr_q;
      rv_d    = 1'b0;
      sum_d   = sum_q;
      own_d   = own_q;
      rerr_d  = rerr_q;
      upd     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // skip the result cycle so the owner has time to drop req
            if (!rv_q && arb_gnt != 2'b00) begin
               base_d  = base_sel;
               acc_d   = '0;
               sub_d   = '0;
               tmo_d   = '0;
               err_d   = 1'b0;
               gnt_d   = arb_gnt;
               busy_d  = 1'b1;
               start_d = 1'b1;
               addr_d  = base_sel;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (eng_done) begin
               acc_d = acc_q + ACC_W'(eng_satd);
               tmo_d = '0;
               if (sub_q == SUB_LAST) begin
                  state_d = ST_REPORT;
               end else begin
                  sub_d   = sub_nxt;
                  start_d = 1'b1;
                  addr_d  = base_q + ADDR_W'(sub_nxt);
                  state_d = ST_ISSUE;
               end
            end else if (tmo_q == TMO_ARM) begin
               err_d   = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            rv_d    = 1'b1;
            sum_d   = acc_q;
            own_d   = gnt_q;
            rerr_d  = err_q;
            upd     = 1'b1;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sub_q   <= '0;
         tmo_q   <= '0;
         acc_q   <= '0;
         base_q  <= '0;
         err_q   <= 1'b0;
         gnt_q   <= 2'b00;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         addr_q  <= '0;
         rv_q    <= 1'b0;
         sum_q   <= '0;
         own_q   <= 2'b00;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         tmo_q   <= tmo_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         err_q   <= err_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         addr_q  <= addr_d;
         rv_q    <= rv_d;
         sum_q   <= sum_d;
         own_q   <= own_d;
         rerr_q  <= rerr_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign eng_start = start_q;
   assign eng_addr  = addr_q;
   assign res_valid = rv_q;
   assign res_sum   = sum_q;
   assign res_owner = own_q;
   assign res_err   = rerr_q;

endmodule
